// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one STAGE_BITS slice per stage.
// Ports: clk, rst, in_valid/in_ready, A, B, cin, sub, out_valid/out_ready, s, cout, ovf, zero.
module cla_addsub_pipe #(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int L = WIDTH / STAGE_BITS;
  localparam int G = STAGE_BITS / 4;

  // Carries c[0..4] of one 4-bit lookahead group.
  function automatic logic [4:0] cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       c0
  );
    logic [3:0] p, g;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic [L-1:0]            vld_q, vld_d;
  logic [L-1:0][WIDTH-1:0] a_q, a_d;
  logic [L-1:0][WIDTH-1:0] b_q, b_d;
  logic [L-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [L-1:0]            c_q, c_d;
  logic [L-1:0]            z_q, z_d;

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [L-1:0][WIDTH-1:0] st_sum;
  logic [L-1:0]            st_co;
  logic [L-1:0]            st_cm;
  logic [L-1:0]            st_z;

  logic adv;

  assign adv       = !ov_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = ov_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Slice arithmetic of every stage from its own registers.
  always_comb begin
    logic [STAGE_BITS:0]   cc;
    logic [STAGE_BITS-1:0] sa, sbv, ss;
    logic [4:0]            gc;
    st_sum = '0;
    st_co  = '0;
    st_cm  = '0;
    st_z   = '0;
    cc     = '0;
    sa     = '0;
    sbv    = '0;
    ss     = '0;
    gc     = '0;
    for (int i = 0; i < L; i++) begin
      sa    = a_q[i][i*STAGE_BITS +: STAGE_BITS];
      sbv   = b_q[i][i*STAGE_BITS +: STAGE_BITS];
      cc    = '0;
      cc[0] = c_q[i];
      for (int j = 0; j < G; j++) begin
        gc = cla4(sa[4*j +: 4], sbv[4*j +: 4], cc[4*j]);
        cc[4*j+1 +: 4] = gc[4:1];
      end
      ss = sa ^ sbv ^ cc[STAGE_BITS-1:0];
      st_sum[i] = sum_q[i];
      st_sum[i][i*STAGE_BITS +: STAGE_BITS] = ss;
      st_co[i] = cc[STAGE_BITS];
      // carry into the top bit of this slice; only the last stage's is used
      st_cm[i] = cc[STAGE_BITS-1];
      st_z[i]  = z_q[i] & ~|ss;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    c_d    = c_q;
    z_d    = z_q;
    ov_d   = ov_q;
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (adv) begin
      vld_d[0] = in_valid;
      a_d[0]   = A;
      b_d[0]   = sub ? ~B : B;
      c_d[0]   = sub | cin;
      sum_d[0] = '0;
      z_d[0]   = 1'b1;
      for (int i = 1; i < L; i++) begin
        vld_d[i] = vld_q[i-1];
        a_d[i]   = a_q[i-1];
        b_d[i]   = b_q[i-1];
        c_d[i]   = st_co[i-1];
        sum_d[i] = st_sum[i-1];
        z_d[i]   = st_z[i-1];
      end
      ov_d = vld_q[L-1];
      // bubbles leave the last result in place
      if (vld_q[L-1]) begin
        s_d    = st_sum[L-1];
        cout_d = st_co[L-1];
        ovf_d  = st_co[L-1] ^ st_cm[L-1];
        zero_d = st_z[L-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      ov_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      ov_q   <= ov_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sum_q <= sum_d;
    c_q   <= c_d;
    z_q   <= z_d;
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Testbench for cla_addsub_pipe (WIDTH=16, STAGE_BITS=4).
// Drives directed, stall, reset and random traffic; scoreboard checks results.
module tb_cla_addsub_pipe;
  localparam int W  = 16;
  localparam int SB = 4;
  localparam int L  = W / SB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout, ovf, zero;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  res_t         sbq[$];
  bit           hold_chk = 0;
  logic [W+2:0] hold_v;

  cla_addsub_pipe #(.WIDTH(W), .STAGE_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   t;
    res_t         r;
    yy  = sb ? ~y : y;
    t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
    r.z = (r.s == '0);
    return r;
  endfunction

  // Inputs and outputs seen here are what the next rising edge samples.
  always @(negedge clk) begin
    res_t e;
    if (hold_chk) begin
      total++;
      if ({s, cout, ovf, zero} !== hold_v || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold: got %h v=%b want %h", {s, cout, ovf, zero}, out_valid, hold_v);
      end
    end
    hold_chk = 0;
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        n_out++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL scoreboard: unexpected result %h", {s, cout, ovf, zero});
        end else begin
          e = sbq.pop_front();
          if ({s, cout, ovf, zero} !== e) begin
            bad++;
            $display("FAIL scoreboard: got s=%h c=%b o=%b z=%b want s=%h c=%b o=%b z=%b",
                     s, cout, ovf, zero, e.s, e.c, e.o, e.z);
          end
        end
      end
      if (out_valid && !out_ready) begin
        hold_chk = 1;
        hold_v   = {s, cout, ovf, zero};
      end
      if (in_valid && in_ready) sbq.push_back(model(a, b, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++;
    if ({s, cout, ovf, zero} !== '0) begin
      bad++; $display("FAIL reset_out: got %h want 0", {s, cout, ovf, zero});
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_add();
    logic [W-1:0] ta[2] = '{16'hFFFF, 16'h7FFF};
    logic [W-1:0] tb[2] = '{16'h0001, 16'h0001};
    logic [W+2:0] te[2] = '{{16'h0000, 1'b1, 1'b0, 1'b1}, {16'h8000, 1'b0, 1'b1, 1'b0}};
    int n;
    for (int i = 0; i < 2; i++) begin
      a = ta[i]; b = tb[i]; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      total++;
      if (n !== L) begin bad++; $display("FAIL add_latency[%0d]: got %0d want %0d", i, n, L); end
      total++;
      if ({s, cout, ovf, zero} !== te[i]) begin
        bad++; $display("FAIL add[%0d]: got %h want %h", i, {s, cout, ovf, zero}, te[i]);
      end
      tick();
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] ta[3] = '{16'h8000, 16'h0003, 16'h1234};
    logic [W-1:0] tb[3] = '{16'h0001, 16'h0005, 16'h1234};
    logic         tc[3] = '{1'b1, 1'b0, 1'b0};
    logic [W+2:0] te[3] = '{{16'h7FFF, 1'b1, 1'b1, 1'b0},
                            {16'hFFFE, 1'b0, 1'b0, 1'b0},
                            {16'h0000, 1'b1, 1'b0, 1'b1}};
    int n;
    for (int i = 0; i < 3; i++) begin
      a = ta[i]; b = tb[i]; cin = tc[i]; sub = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      total++;
      if ({s, cout, ovf, zero} !== te[i] || n !== L) begin
        bad++; $display("FAIL sub[%0d]: got %h lat %0d want %h lat %0d",
                        i, {s, cout, ovf, zero}, n, te[i], L);
      end
      tick();
    end
    sub = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int stall = 0;
    int cyc = 0;
    int n0;
    bit seen = 0;
    logic [W+2:0] snap = '0;
    n0 = n_out;
    out_ready = 1'b1;
    while (cyc < 60 && !(sent == 6 && sbq.size() == 0 && !out_valid)) begin
      if (out_valid && !seen) begin
        seen = 1; stall = 3; snap = {s, cout, ovf, zero};
      end
      out_ready = (stall == 0);
      in_valid = (sent < 6);
      a   = W'(sent * 16'h1111);
      b   = W'(16'h0F0F + sent * 16'h2345);
      cin = ((sent % 2) == 1);
      sub = 1'b0;
      #1;
      if (stall > 0) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready: got %b want 0", in_ready); end
        total++;
        if ({s, cout, ovf, zero} !== snap) begin
          bad++; $display("FAIL b2b_held: got %h want %h", {s, cout, ovf, zero}, snap);
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      if (stall > 0) stall--;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (cyc >= 60) begin bad++; $display("FAIL b2b_timeout: got %0d cycles want <60", cyc); end
    total++;
    if (n_out - n0 !== 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", n_out - n0); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = W'(16'h0101 * (i + 1)); b = 16'h0202; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    total++;
    if ({s, cout, ovf, zero} !== '0) begin
      bad++; $display("FAIL rstmid_out: got %h want 0", {s, cout, ovf, zero});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (8) begin
      tick();
      if (out_valid) seen = 1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_ghost: got %b want 0", seen); end
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    int n0;
    n0 = n_out;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom % 2);
      sub = 1'($urandom % 2);
      #1;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((sbq.size() != 0 || out_valid) && cyc < 40) begin tick(); cyc++; end
    total++;
    if (sent !== 10000) begin bad++; $display("FAIL rand_sent: got %0d want 10000", sent); end
    total++;
    if (n_out - n0 !== sent) begin
      bad++; $display("FAIL rand_count: got %0d want %0d", n_out - n0, sent);
    end
    total++;
    if (sbq.size() !== 0) begin bad++; $display("FAIL rand_drain: got %0d left want 0", sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
